// File: rtl/serial_rx_package_if.sv
// ---------------------------------------------------------------------------
// serial_rx_package_if
//
// Purpose:
//   Parallel output bus of the serial package receiver.  It carries one
//   complete package, a one-cycle strobe when the package updates, and a
//   one-cycle strobe when a frame arrives with a bad stop bit.
//
// Signals:
//   data         package; word k at bits [k*WordWidth +: WordWidth]
//   valid        one-cycle pulse when data updates
//   frame_error  one-cycle pulse on a bad stop bit
//
// Modports:
//   master  driven by the receiver
//   slave   consumed by whatever takes the packages
// ---------------------------------------------------------------------------
interface serial_rx_package_if #(
    parameter int DataWidth = 32
);
    logic [DataWidth-1:0] data;
    logic                 valid;
    logic                 frame_error;

    modport master (
        output data,
        output valid,
        output frame_error
    );

    modport slave (
        input data,
        input valid,
        input frame_error
    );
endinterface

// File: rtl/serial_rx_package.sv
// ---------------------------------------------------------------------------
// serial_rx_package
//
// Purpose:
//   Deserialises 8N1-style frames (start 0, WordWidth data bits LSB first,
//   stop 1) from a single asynchronous line and gathers 2**AddressWidth
//   consecutive words into one package.  The complete package is presented
//   on a parallel bus together with a one-cycle valid strobe.  A bad stop
//   bit raises a one-cycle frame_error strobe and discards the partially
//   assembled package.
//
// Ports:
//   clk          system clock, all logic on the rising edge
//   rst          synchronous active-low reset
//   ce           receive enable; only gates detection of new start bits
//   rx           serial line, idle high, asynchronous to clk
//   pkg          output bus (data / valid / frame_error), master side
//
// Parameters:
//   AddressWidth      log2 of words per package (>= 1)
//   WordWidth         data bits per frame (>= 2)
//   SerialTimerWidth  bit period = 2**SerialTimerWidth clk cycles (>= 2)
// ---------------------------------------------------------------------------
module serial_rx_package #(
    parameter int AddressWidth     = 2,
    parameter int WordWidth        = 8,
    parameter int SerialTimerWidth = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       ce,
    input  logic                       rx,
    serial_rx_package_if.master        pkg
);

    localparam int Words       = 2 ** AddressWidth;
    localparam int PkgWidth    = Words * WordWidth;
    localparam int BitCntWidth = (WordWidth > 1) ? $clog2(WordWidth) : 1;

    // Timer terminal counts: half a bit period to reach the middle of the
    // start bit, then a full period between successive mid-bit samples.
    localparam logic [SerialTimerWidth-1:0] HalfLast =
        SerialTimerWidth'((2 ** SerialTimerWidth) / 2 - 1);
    localparam logic [SerialTimerWidth-1:0] FullLast = '1;
    localparam logic [BitCntWidth-1:0]      BitLast  = BitCntWidth'(WordWidth - 1);
    localparam logic [AddressWidth-1:0]     WordLast = '1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_WAIT_IDLE
    } state_t;

    state_t                                 state_q;
    logic                                   rx_meta_q;
    logic                                   rx_s_q;
    logic [SerialTimerWidth-1:0]            timer_q;
    logic [BitCntWidth-1:0]                 bit_cnt_q;
    logic [WordWidth-1:0]                   shift_q;
    logic [AddressWidth-1:0]                word_idx_q;
    logic [Words-1:0][WordWidth-1:0]        slots_q;
    logic [PkgWidth-1:0]                    data_q;
    logic                                   valid_q;
    logic                                   ferr_q;

    // Package as it will look once the word currently in the shift register
    // is accepted: the slot addressed by word_idx_q is replaced by the fresh
    // word, every other slot comes from storage.  Only loaded into data_q
    // when the last slot is being filled, so data is never partially updated.
    logic [PkgWidth-1:0]                    pkg_d;

    genvar gi;
    generate
        for (gi = 0; gi < Words; gi++) begin : g_pack
            assign pkg_d[gi*WordWidth +: WordWidth] =
                (word_idx_q == AddressWidth'(gi)) ? shift_q : slots_q[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            rx_meta_q  <= 1'b1;
            rx_s_q     <= 1'b1;
            timer_q    <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            word_idx_q <= '0;
            slots_q    <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            // Two-flop synchroniser; every decision below uses rx_s_q.
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;

            // Strobes are high for exactly the cycle after they are set.
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;

            case (state_q)
                ST_IDLE: begin
                    if (ce && !rx_s_q) begin
                        state_q <= ST_START;
                        timer_q <= '0;
                    end
                end

                ST_START: begin
                    if (timer_q == HalfLast) begin
                        timer_q   <= '0;
                        bit_cnt_q <= '0;
                        // A line that is high again at mid start bit was a
                        // glitch: drop back without touching any output.
                        state_q   <= rx_s_q ? ST_IDLE : ST_DATA;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end

                ST_DATA: begin
                    // Timer wraps from FullLast to zero on its own, so it is
                    // already cleared when the stop state is entered.
                    timer_q <= timer_q + 1'b1;
                    if (timer_q == FullLast) begin
                        shift_q   <= {rx_s_q, shift_q[WordWidth-1:1]};
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                        if (bit_cnt_q == BitLast) begin
                            state_q <= ST_STOP;
                        end
                    end
                end

                ST_STOP: begin
                    timer_q <= timer_q + 1'b1;
                    if (timer_q == FullLast) begin
                        if (rx_s_q) begin
                            slots_q[word_idx_q] <= shift_q;
                            if (word_idx_q == WordLast) begin
                                data_q  <= pkg_d;
                                valid_q <= 1'b1;
                            end
                            // Wraps to zero after the last slot.
                            word_idx_q <= word_idx_q + 1'b1;
                            state_q    <= ST_IDLE;
                        end else begin
                            // Bad stop bit: the whole partial package is
                            // abandoned, data keeps the last good package.
                            ferr_q     <= 1'b1;
                            word_idx_q <= '0;
                            state_q    <= ST_WAIT_IDLE;
                        end
                    end
                end

                ST_WAIT_IDLE: begin
                    // A held-low line (break) must not be taken as a run of
                    // start bits; wait for it to return high first.
                    if (rx_s_q) begin
                        state_q <= ST_IDLE;
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign pkg.data        = data_q;
    assign pkg.valid       = valid_q;
    assign pkg.frame_error = ferr_q;

endmodule

// File: doc/serial_rx_package.md
Name: serial_rx_package

Overview:
Serial receiver that is the downstream counterpart of the package transmitter. It deserialises a stream of 8N1-style frames, one word per frame, from a single line. It assembles 2**AddressWidth consecutive words into one package and presents the package on a parallel bus with a one-cycle valid strobe. It closes the loopback path used by the genetic-hardware cores to receive packages from the host or a peer.

Parameters:
AddressWidth, 2, log2 of words per package; package width = 2**AddressWidth*WordWidth
WordWidth, 8, data bits per serial frame
SerialTimerWidth, 3, bit period = 2**SerialTimerWidth clk cycles (must be >= 2)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  reset; synchronous, active-low (rst==0 resets on the clk edge)
ce  input  1  receive enable; gates detection of new start bits only
rx  input  1  serial line, idle high, asynchronous to clk
data  output  2**AddressWidth*WordWidth  last complete package; word k at bits [k*WordWidth +: WordWidth]
valid  output  1  one-cycle pulse when data updates
frame_error  output  1  one-cycle pulse on a bad stop bit

Behaviour:
- Reset (rst==0 at a clk edge), regardless of state:
  - data=0, valid=0, frame_error=0.
  - FSM=IDLE, word index=0, timer=0, bit count=0.
  - rx synchroniser flops=1.
  - Reset mid-frame discards all partial words.
- rx passes through a 2-flop synchroniser (rx_s). All decisions use rx_s.
- Let N=2**SerialTimerWidth and H=N/2.
- Frame format: start bit (0), WordWidth data bits LSB first, stop bit (1).
- FSM states and transitions:
  - IDLE: if ce==1 and rx_s==0, go to START and clear timer. ce==0 ignores the line.
  - START: count H cycles, then sample rx_s.
    - rx_s==0: go to DATA, clear timer and bit count.
    - rx_s==1: false start, return to IDLE; no outputs change.
  - DATA: every N cycles sample rx_s into the shift register (LSB first). After WordWidth samples, go to STOP.
  - STOP: after N cycles sample rx_s.
    - rx_s==1: write the word into slot[word index].
      - If word index == 2**AddressWidth-1: data <= all slots (including this word) on the next edge, valid=1 for exactly that one cycle, word index wraps to 0.
      - Otherwise increment word index.
      - Go to IDLE.
    - rx_s==0: framing error. frame_error=1 for one cycle. Discard the word and all partial slots (word index=0; data unchanged). Go to WAIT_IDLE.
  - WAIT_IDLE: stay until rx_s==1, then go to IDLE. This prevents a break condition from being read as start bits.
- ce only affects IDLE:
  - A frame in progress completes normally when ce drops.
  - A partial package is retained across ce low and resumes at the current word index.
- Latency: valid rises on the clk edge after the stop-bit sample of the last word.
- data holds its value until the next complete package; it is never partially updated.
- valid and frame_error are never high in the same cycle.
- Back-to-back frames with no idle gap must be received: the next start bit is detected in IDLE the cycle after STOP.
- Sampling point is mid-bit. Tolerance of about ±H/N of a bit period over one frame is required (baud mismatch up to ~4% at N=8).

Test Plan:
All scenarios use defaults (N=8, package width 32) and drive rx with an ideal bit period of 8 clk cycles.
- Four frames 0x11, 0x22, 0x33, 0x44 with ce=1 -> one valid pulse of 1 cycle; data=0x44332211 from then on; frame_error never high.
- Frames 0xAA, then 0x55 with stop bit forced 0, then 0x01, 0x02, 0x03, 0x04 -> frame_error pulses once; no valid until the 4th good frame; data=0x04030201 (0xAA discarded).
- rx low for 2 cycles then high while in IDLE -> FSM returns to IDLE; no valid, no frame_error; the next real package is received correctly.
- rst=0 driven mid-way through the 3rd frame of a package, then 4 full frames 0xDE, 0xAD, 0xBE, 0xEF -> data=0 right after reset; data=0xEFBEADDE at the single valid pulse.
- ce=0 during 4 frames -> no valid. Then ce=1 and 0xA1, 0xB2, 0xC3, 0xD4 -> data=0xD4C3B2A1. Dropping ce mid-frame still completes that frame.
- Loopback: serial_tx_package (same parameters, active-low reset adapted) tx drives rx; 20 random 32-bit packages -> each valid data equals the transmitted package, in order, with no frame_error.
